// File: rtl/digit_serial_mac.sv
// Digit-serial multiplier / squarer / multiply-accumulate.
// One DIGIT x DIGIT product per cycle, shifted and summed into psum.
module digit_serial_mac #(
   parameter int WIDTH     = 8,
   parameter int DIGIT     = 4,
   parameter int ACC_GUARD = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               op_a,
   input  logic [WIDTH-1:0]               op_b,
   input  logic [1:0]                     mode,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [2*WIDTH+ACC_GUARD-1:0]   result,
   output logic                           overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * WIDTH;
   localparam int RW = 2 * WIDTH + ACC_GUARD;

   localparam logic [1:0] M_MUL = 2'd0;
   localparam logic [1:0] M_SQR = 2'd1;
   localparam logic [1:0] M_MAC = 2'd2;
   localparam logic [1:0] M_CLR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FINISH,
      S_HOLD
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [1:0]        mode_q, mode_d;
   logic [PW-1:0]     psum_q, psum_d;
   logic [IW-1:0]     i_q, i_d;
   logic [IW-1:0]     j_q, j_d;
   logic [RW-1:0]     acc_q, acc_d;
   logic [RW-1:0]     res_q, res_d;
   logic              ovf_q, ovf_d;
   logic              ov_q, ov_d;

   logic [DIGIT-1:0]   da, db;
   logic [2*DIGIT-1:0] dp;
   logic [PW-1:0]      term;
   logic [RW:0]        mac_sum;
   logic               last_j, last_term;

   assign result    = res_q;
   assign overflow  = ovf_q;
   assign out_valid = ov_q;

   // Current digit pair product, aligned to its weight (doubled for off-diagonal square terms)
   always_comb begin
      da   = a_q[int'(i_q)*DIGIT +: DIGIT];
      db   = b_q[int'(j_q)*DIGIT +: DIGIT];
      dp   = {{DIGIT{1'b0}}, da} * {{DIGIT{1'b0}}, db};
      term = PW'(dp) << (DIGIT * (int'(i_q) + int'(j_q)));
      if (mode_q == M_SQR && j_q > i_q)
         term = term << 1;
      mac_sum   = {1'b0, acc_q} + (RW+1)'(psum_q);
      last_j    = (j_q == IW'(N-1));
      last_term = last_j && (i_q == IW'(N-1));
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      psum_d   = psum_q;
      i_d      = i_q;
      j_d      = j_q;
      acc_d    = acc_q;
      res_d    = res_q;
      ovf_d    = ovf_q;
      ov_d     = ov_q;
      in_ready = (state_q == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d    = op_a;
               b_d    = (mode == M_SQR) ? op_a : op_b;
               mode_d = mode;
               psum_d = '0;
               i_d    = '0;
               j_d    = '0;
               if (mode == M_CLR) begin
                  acc_d   = '0;
                  res_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            psum_d = psum_q + term;
            if (last_term) begin
               state_d = S_FINISH;
            end else if (last_j) begin
               i_d = i_q + 1'b1;
               j_d = (mode_q == M_SQR) ? i_q + 1'b1 : '0;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_FINISH: begin
            if (mode_q == M_MAC) begin
               acc_d = mac_sum[RW-1:0];
               res_d = mac_sum[RW-1:0];
               ovf_d = mac_sum[RW];
            end else begin
               res_d = RW'(psum_q);
               ovf_d = 1'b0;
            end
            ov_d    = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!ov_q) begin
               ov_d = 1'b1;
            end else if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= M_MUL;
         psum_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         psum_q  <= psum_d;
         i_q     <= i_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         ov_q    <= ov_d;
      end
   end

endmodule

// File: tb/tb_digit_serial_mac.sv
// Bench for digit_serial_mac: three parameterisations checked every
// cycle against a transaction-level arithmetic model.
module tb_digit_serial_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [2:0]       iv, ordy;
   logic [2:0][1:0]  md;
   logic [2:0][15:0] opa, opb;
   wire  [2:0]       ovw, irw, ofw;
   wire  [19:0]      r0;
   wire  [35:0]      r1;
   wire  [19:0]      r2;

   digit_serial_mac #(.WIDTH(8), .DIGIT(4), .ACC_GUARD(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irw[0]),
      .op_a(opa[0][7:0]), .op_b(opb[0][7:0]), .mode(md[0]),
      .out_valid(ovw[0]), .out_ready(ordy[0]), .result(r0),
      .overflow(ofw[0]));

   digit_serial_mac #(.WIDTH(16), .DIGIT(4), .ACC_GUARD(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irw[1]),
      .op_a(opa[1]), .op_b(opb[1]), .mode(md[1]),
      .out_valid(ovw[1]), .out_ready(ordy[1]), .result(r1),
      .overflow(ofw[1]));

   digit_serial_mac #(.WIDTH(8), .DIGIT(8), .ACC_GUARD(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irw[2]),
      .op_a(opa[2][7:0]), .op_b(opb[2][7:0]), .mode(md[2]),
      .out_valid(ovw[2]), .out_ready(ordy[2]), .result(r2),
      .overflow(ofw[2]));

   int npass = 0;
   int ntot  = 0;

   // transaction-level model state per DUT
   int          busy  [3];
   bit          m_rdy [3];
   bit          m_ov  [3];
   bit          m_ovf [3];
   logic [63:0] m_res [3];
   logic [63:0] m_acc [3];
   logic [1:0]  p_mode[3];
   logic [63:0] p_a   [3];
   logic [63:0] p_b   [3];

   function automatic int wid(int k);
      return (k == 1) ? 16 : 8;
   endfunction

   function automatic int ndig(int k);
      return (k == 0) ? 2 : (k == 1) ? 4 : 1;
   endfunction

   function automatic int rw(int k);
      return 2 * wid(k) + 4;
   endfunction

   function automatic logic [63:0] mask(int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   function automatic int lat(int k, logic [1:0] m);
      int n;
      n = ndig(k);
      case (m)
         2'd3:    return 1;
         2'd1:    return n * (n + 1) / 2 + 1;
         default: return n * n + 1;
      endcase
   endfunction

   function automatic logic [63:0] res_of(int k);
      case (k)
         0:       return 64'(r0);
         1:       return 64'(r1);
         default: return 64'(r2);
      endcase
   endfunction

   task automatic check(string nm, int k, logic [63:0] act, logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
                    nm, k, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         busy[k]  = 0;
         m_rdy[k] = 1'b1;
         m_ov[k]  = 1'b0;
         m_ovf[k] = 1'b0;
         m_res[k] = '0;
         m_acc[k] = '0;
      end
   endtask

   task automatic complete(int k);
      logic [63:0] s;
      case (p_mode[k])
         2'd0: begin m_res[k] = p_a[k] * p_b[k]; m_ovf[k] = 1'b0; end
         2'd1: begin m_res[k] = p_a[k] * p_a[k]; m_ovf[k] = 1'b0; end
         2'd2: begin
            s        = m_acc[k] + p_a[k] * p_b[k];
            m_ovf[k] = ((s >> rw(k)) & 64'd1) != 0;
            m_acc[k] = s & mask(rw(k));
            m_res[k] = m_acc[k];
         end
         default: ;
      endcase
      m_ov[k] = 1'b1;
   endtask

   // one clock: sample inputs, advance model, compare all DUT outputs
   task automatic tick();
      bit          r;
      bit          acc_s[3];
      bit          rel_s[3];
      logic [1:0]  ms[3];
      logic [63:0] as[3];
      logic [63:0] bs[3];
      r = rst;
      for (int k = 0; k < 3; k++) begin
         acc_s[k] = iv[k] && m_rdy[k];
         rel_s[k] = m_ov[k] && ordy[k];
         ms[k]    = md[k];
         as[k]    = 64'(opa[k]) & mask(wid(k));
         bs[k]    = 64'(opb[k]) & mask(wid(k));
      end
      @(posedge clk);
      #1;
      if (r) begin
         model_reset();
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (rel_s[k]) begin
               m_ov[k]  = 1'b0;
               m_rdy[k] = 1'b1;
            end
            if (acc_s[k]) begin
               m_rdy[k]  = 1'b0;
               p_mode[k] = ms[k];
               p_a[k]    = as[k];
               p_b[k]    = bs[k];
               busy[k]   = lat(k, ms[k]);
               if (ms[k] == 2'd3) begin
                  m_acc[k] = '0;
                  m_res[k] = '0;
                  m_ovf[k] = 1'b0;
               end
            end else if (busy[k] > 0) begin
               busy[k]--;
               if (busy[k] == 0) complete(k);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         check("in_ready", k, 64'(irw[k]), 64'(m_rdy[k]));
         check("out_valid", k, 64'(ovw[k]), 64'(m_ov[k]));
         check("result", k, res_of(k), m_res[k]);
         check("overflow", k, 64'(ofw[k]), 64'(m_ovf[k]));
      end
   endtask

   task automatic do_op(input int k, input logic [1:0] m,
                        input logic [15:0] a, input logic [15:0] b,
                        input int hold, output int l,
                        output logic [63:0] r, output bit of);
      int g;
      g = 0;
      while (!irw[k] && g < 100) begin
         tick();
         g++;
      end
      md[k]  = m;
      opa[k] = a;
      opb[k] = b;
      iv[k]  = 1'b1;
      tick();
      iv[k]  = 1'b0;
      opa[k] = 16'($urandom);
      opb[k] = 16'($urandom);
      md[k]  = 2'($urandom);
      l = 0;
      while (!ovw[k] && l < 300) begin
         tick();
         l++;
      end
      r  = res_of(k);
      of = ofw[k];
      repeat (hold) begin
         iv[k]  = 1'($urandom_range(0, 1));
         md[k]  = 2'($urandom);
         opa[k] = 16'($urandom);
         opb[k] = 16'($urandom);
         tick();
      end
      iv[k]   = 1'b1;
      ordy[k] = 1'b1;
      tick();
      ordy[k] = 1'b0;
      iv[k]   = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          l;
      logic [63:0] r;
      bit          of;
      logic [1:0]  m;
      int          sel;
      rst  = 1'b1;
      iv   = '0;
      ordy = '0;
      md   = '0;
      opa  = '0;
      opb  = '0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_result", 0, 64'(r0), 64'h0);
      check("reset_in_ready", 0, 64'(irw[0]), 64'd1);
      check("reset_out_valid", 0, 64'(ovw[0]), 64'd0);

      // mul 0xFF*0xFF
      do_op(0, 2'd0, 16'hFF, 16'hFF, 2, l, r, of);
      check("mul_lat", 0, 64'(l), 64'd5);
      check("mul_ff", 0, r, 64'h0FE01);
      check("mul_ovf", 0, 64'(of), 64'd0);

      // square ignores op_b
      do_op(0, 2'd1, 16'hB7, 16'h00, 0, l, r, of);
      check("sq_lat", 0, 64'(l), 64'd4);
      check("sq_b7", 0, r, 64'h082D1);
      do_op(0, 2'd1, 16'hB7, 16'h5A, 0, l, r, of);
      check("sq_b7_b5a", 0, r, 64'h082D1);

      // clear then accumulate to wrap
      do_op(0, 2'd3, 16'h0, 16'h0, 0, l, r, of);
      check("clr_lat", 0, 64'(l), 64'd1);
      check("clr_res", 0, r, 64'h0);
      for (int n = 0; n < 16; n++)
         do_op(0, 2'd2, 16'hFF, 16'hFF, n % 3, l, r, of);
      check("mac16", 0, r, 64'hFE010);
      check("mac16_ovf", 0, 64'(of), 64'd0);
      do_op(0, 2'd2, 16'hFF, 16'hFF, 0, l, r, of);
      check("mac17", 0, r, 64'h0DE11);
      check("mac17_ovf", 0, 64'(of), 64'd1);
      do_op(0, 2'd0, 16'h02, 16'h03, 0, l, r, of);
      check("mul_after_mac", 0, r, 64'h6);
      do_op(0, 2'd2, 16'h00, 16'h00, 0, l, r, of);
      check("acc_kept", 0, r, 64'h0DE11);
      check("acc_kept_ovf", 0, 64'(of), 64'd0);

      // long backpressure with in_valid pulses
      do_op(0, 2'd0, 16'h12, 16'h34, 10, l, r, of);
      check("bp_res", 0, r, 64'h3A8);

      // reset in second CALC cycle
      md[0]  = 2'd2;
      opa[0] = 16'h10;
      opb[0] = 16'h10;
      iv[0]  = 1'b1;
      tick();
      iv[0]  = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_out_valid", 0, 64'(ovw[0]), 64'd0);
      check("rst_result", 0, 64'(r0), 64'h0);
      check("rst_in_ready", 0, 64'(irw[0]), 64'd1);
      do_op(0, 2'd2, 16'h02, 16'h03, 0, l, r, of);
      check("mac_after_rst", 0, r, 64'h6);

      // N = 1
      do_op(2, 2'd0, 16'hAB, 16'hCD, 0, l, r, of);
      check("n1_lat", 2, 64'(l), 64'd2);
      check("n1_mul", 2, r, 64'h088EF);

      // WIDTH=16 latencies
      do_op(1, 2'd0, 16'hFFFF, 16'hFFFF, 0, l, r, of);
      check("w16_mul_lat", 1, 64'(l), 64'd17);
      check("w16_mul", 1, r, 64'hFFFE0001);
      do_op(1, 2'd1, 16'h1234, 16'h0, 0, l, r, of);
      check("w16_sq_lat", 1, 64'(l), 64'd11);
      check("w16_sq", 1, r, 64'h014B5A90);
      do_op(1, 2'd2, 16'h0003, 16'h0005, 0, l, r, of);
      check("w16_mac_lat", 1, 64'(l), 64'd17);

      // randomized traffic on all three
      for (int n = 0; n < 240; n++) begin
         sel = (n < 120) ? 1 : (n < 200) ? 0 : 2;
         case ($urandom_range(0, 9))
            0, 1, 2: m = 2'd0;
            3, 4:    m = 2'd1;
            9:       m = 2'd3;
            default: m = 2'd2;
         endcase
         do_op(sel, m, 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), l, r, of);
         check("rand_lat", sel, 64'(l), 64'(lat(sel, m)));
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/digit_serial_mac.md
Name: digit_serial_mac

Overview:
- Parametrised multi-cycle multiplier / multiply-accumulate unit. Reuses one narrow DIGIT x DIGIT combinational multiplier over several cycles and accumulates shifted partial products.
- Generalises our fixed 8-bit, 4-bit-digit squarer to any width and digit size.
- Adds general multiply, optimised squaring and an accumulate mode.
- Valid/ready handshakes on both input and output, so it sits between an operand source (LFSR, pins, register) and a result consumer.

Parameters:
- WIDTH, 8, operand width in bits.
- DIGIT, 4, digit width of the internal multiplier. WIDTH % DIGIT must be 0. N = WIDTH/DIGIT.
- ACC_GUARD, 4, extra accumulator bits above 2*WIDTH. RW = 2*WIDTH+ACC_GUARD.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  WIDTH  operand A (unsigned).
- op_b  in  WIDTH  operand B (unsigned); ignored in square mode.
- mode  in  2  00 mul, 01 square, 10 mac, 11 clear accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  RW  product, zero-extended, or accumulator value.
- overflow  out  1  accumulator wrapped on this mac op.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1 from the first cycle after reset.
  - out_valid = 0, result = 0, overflow = 0.
  - Accumulator acc[RW-1:0] = 0, partial sum psum = 0, digit indices i = j = 0.
- States: IDLE, CALC, FINISH, HOLD.
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - Latch A = op_a. Latch B = op_a in square mode, op_b otherwise. Latch mode.
  - Clear psum, i, j.
  - mode 11: acc <= 0, result <= 0, overflow <= 0, go to HOLD (out_valid after 1 edge).
  - All other modes: go to CALC.
- CALC: one partial product per cycle.
  - psum += (A[i] * B[j]) << (DIGIT*(i+j)).
  - A[i] and B[j] are the i-th and j-th DIGIT-bit digits, LSB digit = 0.
  - psum is 2*WIDTH bits and never overflows.
  - mul and mac: iterate j = 0..N-1 inside i = 0..N-1; N*N cycles.
  - square: iterate only j >= i. For j > i the term is additionally shifted left by 1 (doubled). N*(N+1)/2 cycles.
  - After the last term, go to FINISH.
- FINISH (1 cycle):
  - mul/square: result <= zero-extended psum, overflow <= 0.
  - mac: {carry, sum} = acc + psum. acc <= sum (wraps mod 2^RW), result <= sum, overflow <= carry.
  - out_valid <= 1, go to HOLD.
- Latency (accept edge to out_valid rising edge):
  - mul/mac: N*N+1 edges.
  - square: N*(N+1)/2+1 edges.
  - clear: 1 edge.
- HOLD:
  - result, overflow and out_valid are stable while out_ready = 0, for unbounded cycles.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - in_ready is low in HOLD, so there is always at least one idle cycle between operations. in_valid in the same cycle as the HOLD release is not accepted.
- Input handling:
  - in_valid in CALC/FINISH/HOLD is ignored; operands are not sampled.
  - Operand inputs may change freely after acceptance.
- acc changes only in FINISH of a mac op, on clear, or on rst. mul/square never touch acc.
- result keeps its last value after the handshake until the next FINISH, clear, or rst.
- rst at any cycle (including mid-CALC or HOLD) aborts the operation and restores all reset values, including acc = 0, on that edge.
- N = 1 (DIGIT = WIDTH) is legal: CALC is 1 cycle for all modes.

Test Plan (WIDTH=8, DIGIT=4, ACC_GUARD=4 unless stated):
1. mul op_a=0xFF, op_b=0xFF -> result=0x0FE01, overflow=0, out_valid rises 5 edges after accept; in_ready=0 throughout.
2. square op_a=0xB7, op_b=0x00 -> result=0x082D1 (33489), out_valid 4 edges after accept; op_b=0x5A gives the identical result.
3. clear, then 16x mac 0xFF*0xFF -> final result=0xFE010, overflow=0; 17th mac -> result=0x0DE11, overflow=1; following mul 0x02*0x03 -> result=0x6, acc unchanged (next mac 0*0 returns 0x0DE11).
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid -> result/out_valid stable, no operand accepted; out_ready=1 -> out_valid falls, in_ready=1 on the next cycle.
5. Reset mid-op: mac 0x10*0x10 accepted, rst on the 2nd CALC cycle -> out_valid=0, result=0, in_ready=1 after that edge; next mac 0x02*0x03 -> result=0x6 (acc was cleared).
6. Parameter sweep DIGIT=8 (N=1): mul 0xAB*0xCD -> result=0x088EF, latency 2 edges. WIDTH=16, DIGIT=4: random mul/square/mac against a reference model, latencies 17/11/17 edges.
